// File: rtl/store_rmw_narrow_pkg.sv
// Shared types for the narrow-store read-modify-write unit: size codes, FSM states, captured request.
package store_rmw_narrow_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
        logic [SIZE_W-1:0] size;
    } req_t;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge of store data into an existing memory word.
module store_lane_merge
    import store_rmw_narrow_pkg::*;
(
    input  logic [XLEN-1:0]   old_word,
    input  logic [XLEN-1:0]   new_data,
    input  logic [1:0]        offset,
    input  logic [SIZE_W-1:0] size,
    output logic [XLEN-1:0]   merged_c
);

    // Half stores only look at offset[1]; misaligned low bits are masked away.
    always_comb begin
        merged_c = old_word;
        unique case (size)
            SZ_BYTE: merged_c[{offset, 3'b000} +: 8]     = new_data[7:0];
            SZ_HALF: merged_c[{offset[1], 4'b0000} +: 16] = new_data[15:0];
            SZ_WORD: merged_c = new_data;
            default: merged_c = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_narrow.sv
// Store narrowing unit for a word-wide RAM without byte enables; sub-word stores use read-modify-write.
// Optional macro STORE_MISALIGN_TRAP_EN rejects misaligned half/word stores with err instead of masking.
module store_rmw_narrow
    import store_rmw_narrow_pkg::*;
#(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [SIZE_W-1:0] req_size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_wr_en,
    output logic [XLEN-1:0]   mem_wdata
);

    state_t            state_q, state_d;
    req_t              cap_q, cap_d;
    logic [MEM_AW-1:0] mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_d;
    logic              rd_en_d, wr_en_d, done_d, err_d, ready_d, busy_d;
    logic              accept, misalign, reject;
    logic [XLEN-1:0]   merged_c;
    logic              unused_addr;

    assign unused_addr = ^cap_q.addr[XLEN-1:2];
    assign accept      = req_valid && req_ready;

`ifdef STORE_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign reject = (req_size == SZ_RSVD) || misalign;

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (cap_q.data),
        .offset   (cap_q.addr[1:0]),
        .size     (cap_q.size),
        .merged_c (merged_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = '0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cap_d      = '{addr: req_addr, data: req_data, size: req_size};
                    mem_addr_d = req_addr[MEM_AW+1:2];
                    if (reject) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        state_d     = ST_WR;
                        wr_en_d     = 1'b1;
                        mem_wdata_d = req_data;
                    end else begin
                        state_d = ST_RD;
                        rd_en_d = 1'b1;
                    end
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                state_d     = ST_WR;
                wr_en_d     = 1'b1;
                mem_wdata_d = merged_c;
            end
            ST_WR: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cap_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_rd_en <= rd_en_d;
            mem_wr_en <= wr_en_d;
            done      <= done_d;
            err       <= err_d;
            req_ready <= ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_store_rmw_narrow.sv
// Directed self-checking bench for store_rmw_narrow with a synchronous word RAM stub.
module tb_store_rmw_narrow;
    import store_rmw_narrow_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        busy, done, err;
    logic [9:0]  mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_wdata;

    logic [31:0] ram [0:1023];
    int          total = 0;
    int          passed = 0;
    int          failed = 0;
    int          done_cnt = 0;

    store_rmw_narrow #(.MEM_AW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_word(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] waddr);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = SZ_WORD;
        chk1({tag, ".ready_c0"}, req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1({tag, ".wr_c1"}, mem_wr_en, 1'b1);
        chk1({tag, ".rd_c1"}, mem_rd_en, 1'b0);
        chk32({tag, ".addr_c1"}, 32'(mem_addr), waddr);
        chk32({tag, ".wdata_c1"}, mem_wdata, d);
        step();
        chk1({tag, ".done_c2"}, done, 1'b1);
        chk1({tag, ".err_c2"}, err, 1'b0);
        chk1({tag, ".wr_c2"}, mem_wr_en, 1'b0);
        step();
        chk1({tag, ".ready_c3"}, req_ready, 1'b1);
        chk1({tag, ".done_c3"}, done, 1'b0);
    endtask

    task automatic do_sub(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] waddr, input logic [31:0] exp);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
        chk1({tag, ".ready_c0"}, req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1({tag, ".rd_c1"}, mem_rd_en, 1'b1);
        chk1({tag, ".wr_c1"}, mem_wr_en, 1'b0);
        chk32({tag, ".addr_c1"}, 32'(mem_addr), waddr);
        step();
        chk1({tag, ".rd_c2"}, mem_rd_en, 1'b0);
        chk1({tag, ".wr_c2"}, mem_wr_en, 1'b0);
        step();
        chk1({tag, ".wr_c3"}, mem_wr_en, 1'b1);
        chk1({tag, ".rd_c3"}, mem_rd_en, 1'b0);
        chk32({tag, ".waddr_c3"}, 32'(mem_addr), waddr);
        chk32({tag, ".wdata_c3"}, mem_wdata, exp);
        step();
        chk1({tag, ".done_c4"}, done, 1'b1);
        chk1({tag, ".err_c4"}, err, 1'b0);
        step();
        chk1({tag, ".ready_c5"}, req_ready, 1'b1);
        chk32({tag, ".ram"}, ram[waddr[9:0]], exp);
    endtask

    task automatic do_err(input string tag, input logic [1:0] sz, input logic [31:0] a);
        req_valid = 1'b1; req_addr = a; req_data = 32'hFFFF_FFFF; req_size = sz;
        chk1({tag, ".ready_c0"}, req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1({tag, ".done_c1"}, done, 1'b1);
        chk1({tag, ".err_c1"}, err, 1'b1);
        chk1({tag, ".rd_c1"}, mem_rd_en, 1'b0);
        chk1({tag, ".wr_c1"}, mem_wr_en, 1'b0);
        step();
        chk1({tag, ".ready_c2"}, req_ready, 1'b1);
        chk1({tag, ".done_c2"}, done, 1'b0);
        chk1({tag, ".err_c2"}, err, 1'b0);
    endtask

    initial begin
        logic [31:0] prev;
        int          dc;

        step();
        chk1("rst.ready", req_ready, 1'b1);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.done", done, 1'b0);
        chk1("rst.err", err, 1'b0);
        chk1("rst.rd", mem_rd_en, 1'b0);
        chk1("rst.wr", mem_wr_en, 1'b0);
        chk32("rst.addr", 32'(mem_addr), 32'd0);
        chk32("rst.wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        step();

        do_word("sw_beef", 32'h0000_0010, 32'hDEAD_BEEF, 32'd4);
        do_word("sw_pre1", 32'h0000_0010, 32'h1122_3344, 32'd4);
        do_sub("sb_12", SZ_BYTE, 32'h0000_0012, 32'hFFFF_FFAA, 32'd4, 32'h11AA_3344);
        do_word("sw_pre2", 32'h0000_0010, 32'h1122_3344, 32'd4);
        do_sub("sh_12", SZ_HALF, 32'h0000_0012, 32'h0000_BEEF, 32'd4, 32'hBEEF_3344);
        do_sub("sh_10", SZ_HALF, 32'h0000_0010, 32'h0000_5566, 32'd4, 32'hBEEF_5566);

        dc = done_cnt;
        do_err("rsvd", SZ_RSVD, 32'h0000_0010);
        chk32("rsvd.ram", ram[4], 32'hBEEF_5566);

`ifdef STORE_MISALIGN_TRAP_EN
        do_err("sh_11", SZ_HALF, 32'h0000_0011);
        chk32("sh_11.ram", ram[4], 32'hBEEF_5566);
        do_err("sw_13", SZ_WORD, 32'h0000_0013);
        do_sub("sb_wrap", SZ_BYTE, 32'hFFFF_F013, 32'h0000_0099, 32'd4, 32'h99EF_5566);
`else
        do_sub("sh_11", SZ_HALF, 32'h0000_0011, 32'h0000_7788, 32'd4, 32'hBEEF_7788);
        do_sub("sb_wrap", SZ_BYTE, 32'hFFFF_F013, 32'h0000_0099, 32'd4, 32'h99EF_7788);
`endif

        // Reset lands in WAIT of a byte store: write must never reach the RAM.
        prev = ram[4];
        dc = done_cnt;
        req_valid = 1'b1; req_addr = 32'h0000_0010; req_data = 32'h0000_00EE; req_size = SZ_BYTE;
        step();
        req_valid = 1'b0;
        step();
        chk1("rstmid.busy_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rstmid.ready", req_ready, 1'b1);
        chk1("rstmid.busy", busy, 1'b0);
        chk1("rstmid.wr", mem_wr_en, 1'b0);
        chk1("rstmid.done", done, 1'b0);
        step();
        chk1("rstmid.wr_hold", mem_wr_en, 1'b0);
        rst_n = 1'b1;
        step();
        chk1("rstmid.ready_rel", req_ready, 1'b1);
        chk1("rstmid.wr_rel", mem_wr_en, 1'b0);
        step();
        chk1("rstmid.done_rel", done, 1'b0);
        chk32("rstmid.ram", ram[4], prev);
        chk32("rstmid.done_cnt", 32'(done_cnt), 32'(dc));
        do_word("sw_after_rst", 32'h0000_0010, 32'hCAFE_F00D, 32'd4);

        // Back-to-back: sw is held until the unit returns to IDLE at cycle 5.
        dc = done_cnt;
        req_valid = 1'b1; req_addr = 32'h0000_0010; req_data = 32'h0000_0011; req_size = SZ_BYTE;
        chk1("b2b.ready_c0", req_ready, 1'b1);
        step();
        req_addr = 32'h0000_0014; req_data = 32'h0123_4567; req_size = SZ_WORD;
        chk1("b2b.rd_c1", mem_rd_en, 1'b1);
        chk1("b2b.ready_c1", req_ready, 1'b0);
        step();
        chk1("b2b.ready_c2", req_ready, 1'b0);
        step();
        chk1("b2b.wr_c3", mem_wr_en, 1'b1);
        chk32("b2b.wdata_c3", mem_wdata, 32'hCAFE_F011);
        step();
        chk1("b2b.done_c4", done, 1'b1);
        chk1("b2b.ready_c4", req_ready, 1'b0);
        step();
        chk1("b2b.ready_c5", req_ready, 1'b1);
        chk1("b2b.wr_c5", mem_wr_en, 1'b0);
        step();
        req_valid = 1'b0;
        chk1("b2b.wr_c6", mem_wr_en, 1'b1);
        chk1("b2b.rd_c6", mem_rd_en, 1'b0);
        chk32("b2b.addr_c6", 32'(mem_addr), 32'd5);
        chk32("b2b.wdata_c6", mem_wdata, 32'h0123_4567);
        step();
        chk1("b2b.done_c7", done, 1'b1);
        step();
        chk1("b2b.ready_c8", req_ready, 1'b1);
        chk32("b2b.ram4", ram[4], 32'hCAFE_F011);
        chk32("b2b.ram5", ram[5], 32'h0123_4567);
        chk32("b2b.done_cnt", 32'(done_cnt), 32'(dc + 2));

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
